// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable memory port between instruction fetch and load/store.
// Define MEM_ARB_PERF_CNT_EN to add grant/conflict performance counters.
module mem_port_arbiter #(
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_addr,
    input  logic        ls_we,
    input  logic [2:0]  ls_funct3,
    input  logic [31:0] ls_wdata,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [31:0] ls_resp_data,
    output logic        ls_resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic [3:0]  mem_read_byte_en,
    output logic [3:0]  mem_write_byte_en,
    input  logic [31:0] mem_data_out
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_if_grants,
    output logic [31:0] perf_ls_grants,
    output logic [31:0] perf_conflicts
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_n;
    logic        last_ls, own_ls, we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic        in_idle, in_acc, in_resp;
    logic        gnt_if, gnt_ls, st, bad;
    logic [3:0]  en;
    logic [2:0]  sz;
    logic [32:0] end_addr;
    logic [31:0] ld;

    assign in_idle = reset && (state == IDLE);
    assign in_acc  = reset && (state == ACCESS);
    assign in_resp = reset && (state == RESP);

    // Round-robin: on a tie the requester not granted last time wins
    assign gnt_if = in_idle && if_req_valid && (!ls_req_valid || last_ls);
    assign gnt_ls = in_idle && ls_req_valid && !gnt_if;
    assign st     = own_ls && we_q;

    always_comb begin
        en  = 4'b0000;
        sz  = 3'd0;
        bad = 1'b0;
        if (!own_ls) begin
            en = 4'b1111;
            sz = 3'd4;
        end else begin
            case (f3_q)
                3'b000, 3'b100: begin
                    en = 4'b0001;
                    sz = 3'd1;
                end
                3'b001, 3'b101: begin
                    en = 4'b0011;
                    sz = 3'd2;
                end
                3'b010: begin
                    en = 4'b1111;
                    sz = 3'd4;
                end
                default: bad = 1'b1;
            endcase
            if (we_q && f3_q[2])
                bad = 1'b1;
        end
        end_addr = {1'b0, addr_q} + 33'(sz);
        if (sz == 3'd2 && addr_q[0])
            bad = 1'b1;
        if (sz == 3'd4 && addr_q[1:0] != 2'b00)
            bad = 1'b1;
        if (end_addr > 33'(MEM_SIZE))
            bad = 1'b1;
    end

    always_comb begin
        ld = mem_data_out;
        case (sz)
            3'd1: ld = f3_q[2] ? {24'b0, mem_data_out[7:0]}
                               : {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            3'd2: ld = f3_q[2] ? {16'b0, mem_data_out[15:0]}
                               : {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            default: ld = mem_data_out;
        endcase
    end

    assign mem_address       = in_acc ? addr_q : 32'b0;
    assign mem_read_byte_en  = (in_acc && !bad && !st) ? en : 4'b0000;
    assign mem_write_byte_en = (in_acc && !bad && st) ? en : 4'b0000;
    assign mem_data_in       = (in_acc && !bad && st) ? wdata_q : 32'b0;

    assign if_req_ready  = gnt_if;
    assign ls_req_ready  = gnt_ls;
    assign if_resp_valid = in_resp && !own_ls;
    assign ls_resp_valid = in_resp && own_ls;
    assign if_resp_data  = if_resp_valid ? rdata_q : 32'b0;
    assign ls_resp_data  = ls_resp_valid ? rdata_q : 32'b0;
    assign if_resp_err   = if_resp_valid && err_q;
    assign ls_resp_err   = ls_resp_valid && err_q;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (gnt_if || gnt_ls) state_n = ACCESS;
            ACCESS: state_n = RESP;
            RESP:   if (own_ls ? ls_resp_ready : if_resp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            last_ls <= 1'b1;
            own_ls  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'b0;
            wdata_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (gnt_if) begin
                own_ls  <= 1'b0;
                last_ls <= 1'b0;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                f3_q    <= 3'b010;
                wdata_q <= 32'b0;
            end else if (gnt_ls) begin
                own_ls  <= 1'b1;
                last_ls <= 1'b1;
                addr_q  <= ls_addr;
                we_q    <= ls_we;
                f3_q    <= ls_funct3;
                wdata_q <= ls_wdata;
            end
            if (state == ACCESS) begin
                rdata_q <= (bad || st) ? 32'b0 : ld;
                err_q   <= bad;
            end
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_grants <= 32'b0;
            perf_ls_grants <= 32'b0;
            perf_conflicts <= 32'b0;
        end else begin
            if (gnt_if)
                perf_if_grants <= perf_if_grants + 32'd1;
            if (gnt_ls)
                perf_ls_grants <= perf_ls_grants + 32'd1;
            if (in_idle && if_req_valid && ls_req_valid)
                perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a byte-array memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err;
    logic [31:0] if_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid, ls_resp_ready, ls_resp_err;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr, ls_wdata, ls_resp_data;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic [3:0]  mem_read_byte_en, mem_write_byte_en;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_if_grants, perf_ls_grants, perf_conflicts;
`endif

    mem_port_arbiter #(.MEM_SIZE(4096)) dut (
        .clk(clk), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready),
        .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
        .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready),
        .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_read_byte_en(mem_read_byte_en), .mem_write_byte_en(mem_write_byte_en),
        .mem_data_out(mem_data_out)
`ifdef MEM_ARB_PERF_CNT_EN
        , .perf_if_grants(perf_if_grants), .perf_ls_grants(perf_ls_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];

    always_comb begin
        mem_data_out = 32'b0;
        for (int i = 0; i < 4; i++)
            mem_data_out[8*i +: 8] = mem[12'(mem_address + 32'(i))];
    end

    // Memory contents are (re)loaded while reset is held
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++)
                mem[i] <= 8'h00;
            mem[12'h100] <= 8'hEF;
            mem[12'h101] <= 8'hBE;
            mem[12'h102] <= 8'hAD;
            mem[12'h103] <= 8'hDE;
            mem[12'h203] <= 8'h80;
            mem[12'hFFF] <= 8'h7F;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_write_byte_en[i])
                    mem[12'(mem_address + 32'(i))] <= mem_data_in[8*i +: 8];
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        e;
        string       nm;
    } rsp_t;

    rsp_t if_q[$];
    rsp_t ls_q[$];
    int   order_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: pops expected values whenever a response handshakes
    always @(negedge clk) begin
        rsp_t e;
        if (if_resp_valid && if_resp_ready) begin
            if (if_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_unexpected: got data %h expected no response", if_resp_data);
            end else begin
                e = if_q.pop_front();
                chk({e.nm, "_data"}, if_resp_data, e.d);
                chk({e.nm, "_err"}, {31'b0, if_resp_err}, {31'b0, e.e});
            end
        end
        if (ls_resp_valid && ls_resp_ready) begin
            if (ls_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ls_unexpected: got data %h expected no response", ls_resp_data);
            end else begin
                e = ls_q.pop_front();
                chk({e.nm, "_data"}, ls_resp_data, e.d);
                chk({e.nm, "_err"}, {31'b0, ls_resp_err}, {31'b0, e.e});
            end
        end
    end

    task automatic if_req(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                          input logic [3:0] eren, input string nm);
        bit got = 0;
        @(posedge clk) #1;
        if_addr = a;
        if_req_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (if_req_ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_grant: got no if_req_ready expected grant within 40 cycles", nm);
            if_req_valid = 1'b0;
            return;
        end
        order_q.push_back(0);
        if_q.push_back('{ed, ee, nm});
        @(posedge clk) #1;
        if_req_valid = 1'b0;
        if_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({nm, "_ren"}, {28'b0, mem_read_byte_en}, {28'b0, eren});
        chk({nm, "_wen"}, {28'b0, mem_write_byte_en}, 32'b0);
        @(negedge clk);
        chk({nm, "_rvalid"}, {31'b0, if_resp_valid}, 32'd1);
    endtask

    task automatic ls_req(input logic [31:0] a, input logic we, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                          input logic [3:0] eren, input logic [3:0] ewen,
                          input logic [31:0] edin, input string nm);
        bit got = 0;
        @(posedge clk) #1;
        ls_addr = a;
        ls_we = we;
        ls_funct3 = f3;
        ls_wdata = wd;
        ls_req_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ls_req_ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_grant: got no ls_req_ready expected grant within 40 cycles", nm);
            ls_req_valid = 1'b0;
            return;
        end
        order_q.push_back(1);
        ls_q.push_back('{ed, ee, nm});
        @(posedge clk) #1;
        ls_req_valid = 1'b0;
        ls_wdata = 32'h5555_5555;
        ls_addr = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({nm, "_ren"}, {28'b0, mem_read_byte_en}, {28'b0, eren});
        chk({nm, "_wen"}, {28'b0, mem_write_byte_en}, {28'b0, ewen});
        chk({nm, "_din"}, mem_data_in, edin);
        @(negedge clk);
        chk({nm, "_rvalid"}, {31'b0, ls_resp_valid}, 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        if_addr = 32'h100;
        ls_addr = 32'h0;
        ls_we = 1'b0;
        ls_funct3 = 3'b010;
        ls_wdata = 32'h0;
        if_resp_ready = 1'b1;
        ls_resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_if_ready", {31'b0, if_req_ready}, 32'd0);
        chk("rst_ls_ready", {31'b0, ls_req_ready}, 32'd0);
        chk("rst_ren", {28'b0, mem_read_byte_en}, 32'd0);
        chk("rst_resp_valid", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        @(posedge clk) #1;
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        reset = 1'b1;

        // Contention straight out of reset: IF, LS, then IF again
        fork
            begin
                if_req(32'h100, 32'hDEADBEEF, 1'b0, 4'hF, "rr_if0");
                if_req(32'h100, 32'hDEADBEEF, 1'b0, 4'hF, "rr_if1");
            end
            ls_req(32'h203, 1'b0, 3'b100, 32'h0, 32'h0000_0080, 1'b0,
                   4'h1, 4'h0, 32'h0, "rr_ls");
        join
        chk("rr_order", order_q.size() == 3 ? {order_q[0][7:0], order_q[1][7:0], order_q[2][7:0]} : 32'hFFFF_FFFF,
            {8'h0, 8'h0, 8'h1, 8'h0});
`ifdef MEM_ARB_PERF_CNT_EN
        chk("perf_conflicts", perf_conflicts, 32'd2);
        chk("perf_if_grants", perf_if_grants, 32'd2);
        chk("perf_ls_grants", perf_ls_grants, 32'd1);
`endif

        ls_req(32'h203, 1'b0, 3'b000, 32'h0, 32'hFFFF_FF80, 1'b0, 4'h1, 4'h0, 32'h0, "lb_neg");
        ls_req(32'h203, 1'b0, 3'b100, 32'h0, 32'h0000_0080, 1'b0, 4'h1, 4'h0, 32'h0, "lbu");
        ls_req(32'h40, 1'b1, 3'b001, 32'h1234_ABCD, 32'h0, 1'b0, 4'h0, 4'h3, 32'h1234_ABCD, "sh");
        ls_req(32'h40, 1'b0, 3'b001, 32'h0, 32'hFFFF_ABCD, 1'b0, 4'h3, 4'h0, 32'h0, "lh_after_sh");
        ls_req(32'h40, 1'b0, 3'b010, 32'h0, 32'h0000_ABCD, 1'b0, 4'hF, 4'h0, 32'h0, "lw_after_sh");
        ls_req(32'h100, 1'b0, 3'b101, 32'h0, 32'h0000_BEEF, 1'b0, 4'h3, 4'h0, 32'h0, "lhu");
        ls_req(32'hFFF, 1'b0, 3'b000, 32'h0, 32'h0000_007F, 1'b0, 4'h1, 4'h0, 32'h0, "lb_last");

        if_req(32'h102, 32'h0, 1'b1, 4'h0, "if_misalign");
        ls_req(32'h101, 1'b0, 3'b001, 32'h0, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "lh_misalign");
        ls_req(32'hFFE, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "lw_edge");
        ls_req(32'h1000, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "lw_oor");
        ls_req(32'h1000, 1'b1, 3'b000, 32'hAA, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "sb_oor");
        ls_req(32'h44, 1'b1, 3'b100, 32'h77, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "st_illegal");
        ls_req(32'h44, 1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 4'h0, 4'h0, 32'h0, "ld_illegal");

        // Back-pressured LS response blocks the pending fetch
        @(posedge clk) #1;
        ls_resp_ready = 1'b0;
        ls_req(32'h203, 1'b0, 3'b000, 32'h0, 32'hFFFF_FF80, 1'b0, 4'h1, 4'h0, 32'h0, "hold_lb");
        fork
            if_req(32'h100, 32'hDEADBEEF, 1'b0, 4'hF, "if_after_hold");
        join_none
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, ls_resp_valid}, 32'd1);
            chk("hold_data", ls_resp_data, 32'hFFFF_FF80);
            chk("hold_if_ready", {31'b0, if_req_ready}, 32'd0);
        end
        @(posedge clk) #1;
        ls_resp_ready = 1'b1;
        wait fork;

        // Reset asserted while a store sits in ACCESS
        @(posedge clk) #1;
        ls_addr = 32'h80;
        ls_we = 1'b1;
        ls_funct3 = 3'b010;
        ls_wdata = 32'hCAFE_F00D;
        ls_req_valid = 1'b1;
        @(negedge clk);
        chk("rstacc_grant", {31'b0, ls_req_ready}, 32'd1);
        @(posedge clk) #1;
        ls_req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rstacc_wen", {28'b0, mem_write_byte_en}, 32'd0);
        @(posedge clk) #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rstacc_resp", {30'b0, if_resp_valid, ls_resp_valid}, 32'd0);
            chk("rstacc_addr", mem_address, 32'd0);
        end
        chk("rstacc_mem", {mem[12'h83], mem[12'h82], mem[12'h81], mem[12'h80]}, 32'd0);

        for (int i = 0; i < 20 && (if_q.size() + ls_q.size()) != 0; i++)
            @(negedge clk);
        if ((if_q.size() + ls_q.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0", if_q.size() + ls_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Per access: arbitrates between the two, generates read/write byte enables from the RV32I funct3, aligns store data, and sign/zero-extends load data.
- Flags misaligned, out-of-range and illegal-funct3 accesses as errors without touching memory.
- Sits between the core's front/back ends and the byte-accessible memory; the memory reads combinationally and writes on the clock edge.

Parameters:
- MEM_SIZE, 4096: memory size in bytes; used for the range check.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  32  fetch byte address (word access)
- if_resp_valid  out  1  fetch response valid
- if_resp_ready  in  1  fetch response consumed
- if_resp_data  out  32  fetched word
- if_resp_err  out  1  fetch fault
- ls_req_valid  in  1  load/store request valid
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_addr  in  32  byte address
- ls_we  in  1  1 = store, 0 = load
- ls_funct3  in  3  RV32I funct3 (access size/sign)
- ls_wdata  in  32  store data, right-justified
- ls_resp_valid  out  1  load/store response valid
- ls_resp_ready  in  1  load/store response consumed
- ls_resp_data  out  32  extended load data (0 for stores)
- ls_resp_err  out  1  load/store fault
- mem_address  out  32  memory byte address
- mem_data_in  out  32  memory write data
- mem_read_byte_en  out  4  memory read lane enables
- mem_write_byte_en  out  4  memory write lane enables
- mem_data_out  in  32  memory read data (combinational)

Behaviour:
- Reset is synchronous, active-low; clock is clk. While reset=0:
  - FSM goes to IDLE; last_grant = LS, so IF wins the first tie.
  - All *_ready, *_resp_valid, *_resp_err, mem_*_byte_en = 0.
  - resp_data, mem_address, mem_data_in = 0.
- Reset mid-access drops the in-flight request with no response. A write cannot complete, because write enables exist only in ACCESS.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - One requester valid: that requester wins.
  - Both valid: the requester opposite last_grant wins (round-robin).
  - On a win: the winner's *_req_ready = 1 for exactly that cycle; latch addr, we, funct3, wdata and owner; update last_grant; go to ACCESS.
  - Nothing valid: stay in IDLE.
  - *_req_ready is never asserted outside IDLE.
- ACCESS (one cycle): drive mem_address = latched addr.
  - Size encoding:
    - funct3 000/100 = byte, enables 0001.
    - 001/101 = half, enables 0011.
    - 010 = word, enables 1111.
    - Fetch is always word.
  - Load: mem_read_byte_en = enables. Capture mem_data_out masked to size.
    - Sign-extend for 000 and 001; zero-extend for 100, 101 and 010.
  - Store: mem_write_byte_en = enables, mem_data_in = wdata; resp_data = 0.
  - Store funct3 other than 000/001/010 is illegal.
  - Error check happens before the memory is driven; on error, both enable buses stay 0, resp_data = 0 and resp_err = 1. Error conditions:
    - Half access with addr[0] = 1.
    - Word access (including fetch) with addr[1:0] ≠ 0.
    - Illegal funct3: 011/110/111 for loads, anything outside 000/001/010 for stores.
    - addr + size > MEM_SIZE, computed 33-bit with no wrap.
  - Then go to RESP.
- RESP:
  - Assert the owner's *_resp_valid with data and err held stable.
  - On owner *_resp_ready = 1: deassert next cycle and go to IDLE.
  - The non-owner's resp_valid stays 0.
- Byte enables are 0 in IDLE and RESP.
- Minimum 3 cycles per access. No pipelining, one outstanding access total.
- Requests are not required to hold stable after acceptance, since they are latched.

Optional Feature:
- MEM_ARB_PERF_CNT_EN defined: adds outputs perf_if_grants[31:0], perf_ls_grants[31:0] and perf_conflicts[31:0].
  - Grant counters increment on each grant to that requester.
  - perf_conflicts increments on each IDLE cycle with both requests valid.
  - All three reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Fetch only, word 0x0000_0100 = 0xDEADBEEF at if_addr=0x100 -> if_req_ready at cycle 0; read enables 1111 at cycle 1; if_resp_valid at cycle 2 with data 0xDEADBEEF, err 0.
- Load byte at ls_addr=0x203 holding 0x80, funct3 000 -> ls_resp_data 0xFFFFFF80. Same access with funct3 100 -> 0x00000080.
- Store half, funct3 001, wdata 0x1234ABCD, addr 0x40 -> in ACCESS, mem_write_byte_en=0011 and mem_data_in=0x1234ABCD; ls_resp_data 0, err 0.
- Both requesters valid in IDLE from reset -> IF granted first, LS second, IF third if it re-requests; with MEM_ARB_PERF_CNT_EN, perf_conflicts counts each contended cycle.
- Misaligned accesses (word at 0x102, half at 0x101) and out-of-range access (word at MEM_SIZE-2) -> resp_err 1, data 0, both enable buses 0 throughout.
- ls_resp_ready held 0 for 5 cycles -> ls_resp_valid and data stay stable and IF is not granted; reset=0 in ACCESS -> no response, all outputs 0 next cycle.
